// File: rtl/debounce_multi.sv
// N-channel push-button conditioner: 2-FF sync, tick-based debounce, press/release/long-press strobes.
// A single 1 ms prescaler is shared by all channels.
module debounce_multi #(
    parameter int CLK_FREQ   = 25_000_000,
    parameter int STABLE_MS  = 10,
    parameter int LONG_MS    = 1000,
    parameter int N          = 4,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] btn_i,
    output logic [N-1:0] level_o,
    output logic [N-1:0] press_o,
    output logic [N-1:0] release_o,
    output logic [N-1:0] long_o,
    output logic         tick_o
);

    localparam int TICK_DIV = CLK_FREQ / 1000;
    localparam int PW       = $clog2(TICK_DIV);
    localparam int CW       = $clog2(STABLE_MS + 1);
    localparam int HW       = $clog2(LONG_MS + 1);

    logic [PW-1:0] pre_q, pre_d;
    logic          tick_q, tick_d;

    logic [N-1:0]  s1_q, s1_d;
    logic [N-1:0]  s2_q, s2_d;
    logic [N-1:0]  level_q, level_d;
    logic [N-1:0]  press_q, press_d;
    logic [N-1:0]  release_q, release_d;
    logic [N-1:0]  long_q, long_d;
    logic [CW-1:0] cnt_q  [N];
    logic [CW-1:0] cnt_d  [N];
    logic [HW-1:0] hold_q [N];
    logic [HW-1:0] hold_d [N];

    // tick_q is registered from the next prescaler value, so it is high exactly while pre_q == TICK_DIV-1
    always_comb begin
        pre_d  = (pre_q == PW'(TICK_DIV - 1)) ? '0 : pre_q + 1'b1;
        tick_d = (pre_d == PW'(TICK_DIV - 1));
    end

    always_comb begin
        s1_d      = btn_i ^ {N{ACTIVE_LOW}};
        s2_d      = s1_q;
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        long_d    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cnt_d[i]  = cnt_q[i];
            hold_d[i] = hold_q[i];

            if (s2_q[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (tick_q) begin
                if (cnt_q[i] == CW'(STABLE_MS - 1)) begin
                    level_d[i]   = s2_q[i];
                    cnt_d[i]     = '0;
                    press_d[i]   = s2_q[i];
                    release_d[i] = ~s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end

            // saturation at LONG_MS is what keeps long_o from repeating
            if (!level_q[i]) begin
                hold_d[i] = '0;
            end else if (tick_q && hold_q[i] != HW'(LONG_MS)) begin
                hold_d[i] = hold_q[i] + 1'b1;
                long_d[i] = (hold_q[i] == HW'(LONG_MS - 1));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q     <= '0;
            tick_q    <= 1'b0;
            s1_q      <= '0;
            s2_q      <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            long_q    <= '0;
            cnt_q     <= '{default: '0};
            hold_q    <= '{default: '0};
        end else begin
            pre_q     <= pre_d;
            tick_q    <= tick_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign long_o    = long_q;
    assign tick_o    = tick_q;

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: two instances (active-high and active-low with inverted inputs)
// compared every cycle against a time-based reference model, plus directed latency checks.
module tb_debounce_multi;

    localparam int CLK_FREQ  = 10_000;
    localparam int STABLE_MS = 3;
    localparam int LONG_MS   = 5;
    localparam int N         = 4;
    localparam int TICK_DIV  = CLK_FREQ / 1000;

    logic         clk;
    logic         rst;
    logic [N-1:0] btn;
    logic [N-1:0] btn_n;
    logic [N-1:0] level_a, press_a, release_a, long_a;
    logic [N-1:0] level_b, press_b, release_b, long_b;
    logic         tick_a, tick_b;

    int checks = 0;
    int errors = 0;

    assign btn_n = ~btn;

    debounce_multi #(
        .CLK_FREQ(CLK_FREQ), .STABLE_MS(STABLE_MS), .LONG_MS(LONG_MS), .N(N), .ACTIVE_LOW(1'b0)
    ) dut_a (
        .clk(clk), .reset(rst), .btn_i(btn),
        .level_o(level_a), .press_o(press_a), .release_o(release_a), .long_o(long_a), .tick_o(tick_a)
    );

    debounce_multi #(
        .CLK_FREQ(CLK_FREQ), .STABLE_MS(STABLE_MS), .LONG_MS(LONG_MS), .N(N), .ACTIVE_LOW(1'b1)
    ) dut_b (
        .clk(clk), .reset(rst), .btn_i(btn_n),
        .level_o(level_b), .press_o(press_b), .release_o(release_b), .long_o(long_b), .tick_o(tick_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: m_k counts edges since the last reset edge; ticks occur at m_k % TICK_DIV == TICK_DIV-1.
    // A run of "synchronised input differs from level" that has seen STABLE_MS ticks flips the level;
    // a press that has seen LONG_MS ticks yields long-press.
    int           m_k;
    logic [N-1:0] m_s1, m_s2, m_level, m_press, m_release, m_long;
    logic         m_tick;
    int           dstart [N];
    int           pstart [N];

    function automatic int ticks_in(input int a, input int b);
        return (b + 1) / TICK_DIV - a / TICK_DIV;
    endfunction

    task automatic model_edge();
        int           pk;
        logic [N-1:0] ps2, plev;
        logic         ptick;
        bit           flipped;
        if (rst) begin
            m_k = 0; m_s1 = '0; m_s2 = '0; m_level = '0;
            m_press = '0; m_release = '0; m_long = '0; m_tick = 1'b0;
            for (int c = 0; c < N; c++) begin
                dstart[c] = -1;
                pstart[c] = -1;
            end
        end else begin
            pk = m_k; ps2 = m_s2; plev = m_level; ptick = m_tick;
            m_k = pk + 1;
            m_s2 = m_s1;
            m_s1 = btn;
            m_press = '0; m_release = '0; m_long = '0;
            for (int c = 0; c < N; c++) begin
                flipped = 1'b0;
                if (dstart[c] >= 0 && ptick && ticks_in(dstart[c], pk) == STABLE_MS) begin
                    m_level[c]   = ps2[c];
                    m_press[c]   = ps2[c];
                    m_release[c] = !ps2[c];
                    flipped      = 1'b1;
                    if (ps2[c]) pstart[c] = m_k;
                end
                if (plev[c] && ptick && ticks_in(pstart[c], pk) == LONG_MS) m_long[c] = 1'b1;
                if (m_s2[c] != m_level[c]) begin
                    if (dstart[c] < 0 || flipped) dstart[c] = m_k;
                end else begin
                    dstart[c] = -1;
                end
            end
            m_tick = (m_k % TICK_DIV == TICK_DIV - 1);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_range(input string tag, input int v, input int lo, input int hi);
        checks++;
        assert (v >= lo && v <= hi) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, v, lo, hi);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("level_a",   32'(level_a),   32'(m_level));
        chk("press_a",   32'(press_a),   32'(m_press));
        chk("release_a", 32'(release_a), 32'(m_release));
        chk("long_a",    32'(long_a),    32'(m_long));
        chk("tick_a",    32'(tick_a),    32'(m_tick));
        chk("level_b",   32'(level_b),   32'(m_level));
        chk("press_b",   32'(press_b),   32'(m_press));
        chk("release_b", 32'(release_b), 32'(m_release));
        chk("long_b",    32'(long_b),    32'(m_long));
        chk("tick_b",    32'(tick_b),    32'(m_tick));
    endtask

    // kind: 0 press, 1 release, 2 long; n = steps taken, -1 if the bound expired
    task automatic wait_strobe(input int kind, input int ch, input int bound, output int n);
        logic hit;
        hit = 1'b0;
        n = 0;
        while (!hit && n < bound) begin
            step();
            n++;
            hit = (kind == 0) ? press_a[ch] : (kind == 1) ? release_a[ch] : long_a[ch];
        end
        if (!hit) n = -1;
    endtask

    initial begin
        int n, cnt, dur;
        rst = 1'b1;
        btn = '0;

        // reset and prescaler phase
        for (int i = 0; i < 5; i++) step();
        chk("rst_level", 32'(level_a), 32'(0));
        chk("rst_tick",  32'(tick_a),  32'(0));
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 40 && !tick_a; i++) begin step(); n++; end
        chk("first_tick_steps", 32'(n), 32'(TICK_DIV - 1));
        n = 0;
        step(); n++;
        for (int i = 0; i < 40 && !tick_a; i++) begin step(); n++; end
        chk("tick_period", 32'(n), 32'(TICK_DIV));

        // clean press / release on channel 0, random start phase
        for (int i = 0; i < int'($urandom_range(0, 9)); i++) step();
        btn[0] = 1'b1;
        wait_strobe(0, 0, 200, n);
        chk_range("press0_latency", n - 2, 21, 30);
        chk("press0_level", 32'(level_a[0]), 32'(1));
        for (int i = 0; i < int'($urandom_range(5, 30)); i++) step();
        btn[0] = 1'b0;
        wait_strobe(1, 0, 200, n);
        chk_range("release0_latency", n - 2, 21, 30);
        chk("release0_level", 32'(level_a[0]), 32'(0));

        // bounce rejection on channel 1: random toggle period shorter than a qualification window
        dur = $urandom_range(3, 9);
        cnt = 0;
        for (int t = 0; t < 14; t++) begin
            btn[1] = (t % 2 == 0);
            for (int i = 0; i < dur; i++) begin
                step();
                if (press_a[1] || release_a[1]) cnt++;
            end
        end
        chk("bounce_quiet", 32'(cnt), 32'(0));
        btn[1] = 1'b1;
        wait_strobe(0, 1, 200, n);
        chk_range("bounce_press_latency", n - 2, 21, 30);
        btn[1] = 1'b0;
        wait_strobe(1, 1, 200, n);

        // long press on channel 2, twice
        for (int r = 0; r < 2; r++) begin
            btn[2] = 1'b1;
            wait_strobe(0, 2, 200, n);
            chk_range("long_press_latency", n - 2, 21, 30);
            wait_strobe(2, 2, 200, n);
            chk_range("long_latency", n, 41, 50);
            cnt = 0;
            for (int i = 0; i < 100; i++) begin
                step();
                if (long_a[2]) cnt++;
            end
            chk("long_no_repeat", 32'(cnt), 32'(0));
            btn[2] = 1'b0;
            wait_strobe(1, 2, 200, n);
            chk_range("long_release_latency", n - 2, 21, 30);
        end

        // simultaneous channels; dut_b sees the inverted pattern 4'b0100
        btn = 4'b1011;
        wait_strobe(0, 0, 200, n);
        chk("simul_press_a", 32'(press_a), 32'(4'b1011));
        chk("simul_press_b", 32'(press_b), 32'(4'b1011));
        btn = '0;
        wait_strobe(1, 0, 200, n);
        chk("simul_release_a", 32'(release_a), 32'(4'b1011));

        // random patterns with occasional resets
        for (int seg = 0; seg < 60; seg++) begin
            btn = N'($urandom);
            dur = $urandom_range(1, 60);
            for (int i = 0; i < dur; i++) step();
            if ($urandom_range(0, 9) == 0) begin
                rst = 1'b1;
                for (int i = 0; i < int'($urandom_range(1, 4)); i++) step();
                rst = 1'b0;
            end
        end

        // reset mid-qualification (ch3 cnt=2) and mid-hold (ch2 hold=4) with buttons still pressed
        btn = '0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step();
        rst = 1'b0;
        btn[2] = 1'b1;
        wait_strobe(0, 2, 200, n);
        for (int i = 0; i < 24; i++) step();
        btn[3] = 1'b1;
        for (int i = 0; i < 19; i++) step();
        rst = 1'b1;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (press_a != '0 || release_a != '0 || long_a != '0) cnt++;
        end
        chk("rst_no_strobe", 32'(cnt), 32'(0));
        rst = 1'b0;
        wait_strobe(0, 2, 200, n);
        chk("rst_repress_latency", 32'(n), 32'(STABLE_MS * TICK_DIV));
        chk("rst_repress_both", 32'(press_a), 32'(4'b1100));
        wait_strobe(2, 2, 200, n);
        chk("rst_long_latency", 32'(n), 32'(LONG_MS * TICK_DIV));
        chk("rst_long_both", 32'(long_a), 32'(4'b1100));
        btn = '0;
        wait_strobe(1, 2, 200, n);
        chk_range("final_release_latency", n - 2, 21, 30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
